rd_mode_select: RTL and testbench

Generic rate-distortion mode selector for the intra encoder path. It sequences up to NUM_MODES candidate predictions through an external evaluator (reconstruct + SSE + spectral distortion + rate cost). It scores each result, keeps the best result and its payload, and rescores the winner with the final lambda. It generalises the fixed 4-mode 16x16 picker with a parametrised mode count, a per-block mode enable mask, a per-mode fixed-cost bus, out-of-order result handshakes and an abort.

---
 rtl/rd_mode_select_if.sv | 48 ++++
 rtl/rd_mode_select.sv | 237 +++++++++++++++++++++++
 tb/tb_rd_mode_select.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rd_mode_select_if.sv
// Bus between the mode selector, its controller and the external RD evaluator.
// The selector takes the slave modport; the controller/evaluator side takes master.
interface rd_mode_select_if #(
  parameter int NUM_MODES = 4,
  parameter int MODE_W    = 2,
  parameter int PAYLOAD_W = 6432
);
  logic                     start;
  logic                     abort;
  logic [NUM_MODES-1:0]     mode_mask;
  logic [16*NUM_MODES-1:0]  fixed_cost;
  logic [31:0]              lambda_sel;
  logic [31:0]              tlambda;
  logic [31:0]              lambda_final;
  logic                     eval_start;
  logic [MODE_W-1:0]        eval_mode;
  logic                     sse_valid;
  logic [31:0]              sse;
  logic                     disto_valid;
  logic [31:0]              disto;
  logic                     rate_valid;
  logic [31:0]              rate;
  logic [PAYLOAD_W-1:0]     payload;
  logic [MODE_W-1:0]        best_mode;
  logic [PAYLOAD_W-1:0]     best_payload;
  logic [31:0]              best_D;
  logic [31:0]              best_SD;
  logic [31:0]              best_R;
  logic [63:0]              best_score;
  logic [63:0]              final_score;
  logic                     none_valid;
  logic                     busy;
  logic                     done;

  modport master (
    output start, abort, mode_mask, fixed_cost, lambda_sel, tlambda, lambda_final,
           sse_valid, sse, disto_valid, disto, rate_valid, rate, payload,
    input  eval_start, eval_mode, best_mode, best_payload, best_D, best_SD, best_R,
           best_score, final_score, none_valid, busy, done
  );

  modport slave (
    input  start, abort, mode_mask, fixed_cost, lambda_sel, tlambda, lambda_final,
           sse_valid, sse, disto_valid, disto, rate_valid, rate, payload,
    output eval_start, eval_mode, best_mode, best_payload, best_D, best_SD, best_R,
           best_score, final_score, none_valid, busy, done
  );
endinterface

// File: rtl/rd_mode_select.sv
// Rate-distortion mode selector: walks enabled modes high to low through an
// external evaluator, scores each result and keeps the lowest-scoring winner.
module rd_mode_select #(
  parameter int NUM_MODES = 4,
  parameter int MODE_W    = 2,
  parameter int PAYLOAD_W = 6432
) (
  input  logic          clk,
  input  logic          rst_n,
  rd_mode_select_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SCORE,
    S_COMP,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [MODE_W-1:0]     idx_q, idx_d;
  logic [NUM_MODES-1:0]  mask_q, mask_d;
  logic                  first_wait_q, first_wait_d;
  logic [2:0]            flags_q, flags_d;
  logic [31:0]           d_q, d_d;
  logic [31:0]           sd_q, sd_d;
  logic [31:0]           r_q, r_d;
  logic [63:0]           score_q, score_d;
  logic [63:0]           cand_final_q, cand_final_d;
  logic [MODE_W-1:0]     eval_mode_q, eval_mode_d;
  logic [MODE_W-1:0]     best_mode_q, best_mode_d;
  logic [PAYLOAD_W-1:0]  best_payload_q, best_payload_d;
  logic [31:0]           best_d_q, best_d_d;
  logic [31:0]           best_sd_q, best_sd_d;
  logic [31:0]           best_r_q, best_r_d;
  logic [63:0]           best_score_q, best_score_d;
  logic [63:0]           final_score_q, final_score_d;
  logic                  none_valid_q, none_valid_d;
  logic                  have_best_q, have_best_d;

  logic [15:0]           h_arr [NUM_MODES];
  logic [15:0]           h_sel;
  logic [63:0]           cand_score;
  logic [63:0]           cand_final;
  logic [2:0]            vld;
  logic [2:0]            flags_all;

  for (genvar gi = 0; gi < NUM_MODES; gi++) begin : g_cost
    assign h_arr[gi] = bus.fixed_cost[16*gi +: 16];
  end

  // Products are taken modulo 2^64; the low 64 bits are identical for
  // signed and unsigned operands, so sign-extending lambda is enough.
  function automatic logic [63:0] rd_cost(
    input logic [31:0] r,
    input logic [15:0] h,
    input logic [31:0] d,
    input logic [31:0] sd,
    input logic [31:0] lam,
    input logic [31:0] tl
  );
    logic [63:0] lam64;
    logic [63:0] tl64;
    logic [63:0] rate_term;
    lam64     = {{32{lam[31]}}, lam};
    tl64      = {{32{tl[31]}}, tl};
    rate_term = ({32'd0, r} << 10) + {48'd0, h};
    return rate_term * lam64 + ({32'd0, d} << 8) + {32'd0, sd} * tl64;
  endfunction

  assign h_sel      = h_arr[idx_q];
  assign cand_score = rd_cost(r_q, h_sel, d_q, sd_q, bus.lambda_sel, bus.tlambda);
  assign cand_final = rd_cost(r_q, h_sel, d_q, sd_q, bus.lambda_final, bus.tlambda);
  assign vld        = {bus.rate_valid, bus.disto_valid, bus.sse_valid};
  assign flags_all  = flags_q | vld;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    mask_d         = mask_q;
    first_wait_d   = first_wait_q;
    flags_d        = flags_q;
    d_d            = d_q;
    sd_d           = sd_q;
    r_d            = r_q;
    score_d        = score_q;
    cand_final_d   = cand_final_q;
    eval_mode_d    = eval_mode_q;
    best_mode_d    = best_mode_q;
    best_payload_d = best_payload_q;
    best_d_d       = best_d_q;
    best_sd_d      = best_sd_q;
    best_r_d       = best_r_q;
    best_score_d   = best_score_q;
    final_score_d  = final_score_q;
    none_valid_d   = none_valid_q;
    have_best_d    = have_best_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          mask_d         = bus.mode_mask;
          idx_d          = MODE_W'(NUM_MODES - 1);
          best_mode_d    = '0;
          best_payload_d = '0;
          best_d_d       = '0;
          best_sd_d      = '0;
          best_r_d       = '0;
          best_score_d   = '0;
          final_score_d  = '0;
          none_valid_d   = 1'b0;
          have_best_d    = 1'b0;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mask_q[idx_q]) begin
          eval_mode_d  = idx_q;
          flags_d      = '0;
          first_wait_d = 1'b1;
          state_d      = S_WAIT;
        end else if (idx_q == '0) begin
          none_valid_d = !have_best_q;
          state_d      = S_DONE;
        end else begin
          idx_d = idx_q - MODE_W'(1);
        end
      end
      S_WAIT: begin
        first_wait_d = 1'b0;
        if (bus.sse_valid)   d_d  = bus.sse;
        if (bus.disto_valid) sd_d = bus.disto;
        if (bus.rate_valid)  r_d  = bus.rate;
        flags_d = flags_all;
        if (&flags_all) state_d = S_SCORE;
      end
      S_SCORE: begin
        score_d      = cand_score;
        cand_final_d = cand_final;
        state_d      = S_COMP;
      end
      S_COMP: begin
        // <= while scanning downward lets the lowest index win ties
        if (!have_best_q || ($signed(score_q) <= $signed(best_score_q))) begin
          best_mode_d    = idx_q;
          best_score_d   = score_q;
          best_d_d       = d_q;
          best_sd_d      = sd_q;
          best_r_d       = r_q;
          best_payload_d = bus.payload;
          final_score_d  = cand_final_q;
          have_best_d    = 1'b1;
        end
        if (idx_q == '0) begin
          none_valid_d = 1'b0;
          state_d      = S_DONE;
        end else begin
          idx_d   = idx_q - MODE_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      first_wait_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      mask_q         <= '0;
      first_wait_q   <= 1'b0;
      flags_q        <= '0;
      d_q            <= '0;
      sd_q           <= '0;
      r_q            <= '0;
      score_q        <= '0;
      cand_final_q   <= '0;
      eval_mode_q    <= '0;
      best_mode_q    <= '0;
      best_payload_q <= '0;
      best_d_q       <= '0;
      best_sd_q      <= '0;
      best_r_q       <= '0;
      best_score_q   <= '0;
      final_score_q  <= '0;
      none_valid_q   <= 1'b0;
      have_best_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      mask_q         <= mask_d;
      first_wait_q   <= first_wait_d;
      flags_q        <= flags_d;
      d_q            <= d_d;
      sd_q           <= sd_d;
      r_q            <= r_d;
      score_q        <= score_d;
      cand_final_q   <= cand_final_d;
      eval_mode_q    <= eval_mode_d;
      best_mode_q    <= best_mode_d;
      best_payload_q <= best_payload_d;
      best_d_q       <= best_d_d;
      best_sd_q      <= best_sd_d;
      best_r_q       <= best_r_d;
      best_score_q   <= best_score_d;
      final_score_q  <= final_score_d;
      none_valid_q   <= none_valid_d;
      have_best_q    <= have_best_d;
    end
  end

  assign bus.eval_start   = (state_q == S_WAIT) && first_wait_q && !bus.abort;
  assign bus.eval_mode    = eval_mode_q;
  assign bus.best_mode    = best_mode_q;
  assign bus.best_payload = best_payload_q;
  assign bus.best_D       = best_d_q;
  assign bus.best_SD      = best_sd_q;
  assign bus.best_R       = best_r_q;
  assign bus.best_score   = best_score_q;
  assign bus.final_score  = final_score_q;
  assign bus.none_valid   = none_valid_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE) && !bus.abort;

endmodule

// File: tb/tb_rd_mode_select.sv
// Randomized bench for rd_mode_select: a behavioural evaluator answers each
// eval_start and a score model picks the expected winner per transaction.
module tb_rd_mode_select;

  localparam int NM = 4;
  localparam int MW = 2;
  localparam int PW = 6432;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rd_mode_select_if #(.NUM_MODES(NM), .MODE_W(MW), .PAYLOAD_W(PW)) bus ();

  rd_mode_select #(.NUM_MODES(NM), .MODE_W(MW), .PAYLOAD_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [NM-1:0] mask_v;
  int            lam, tlam, lamf;
  int unsigned   h_v[NM], d_v[NM], sd_v[NM], r_v[NM];
  int            hs;
  int            ofs_s[NM], ofs_d[NM], ofs_r[NM];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint cost(input int m, input int l);
    longint r, h, d, sd, lw, tw;
    r  = longint'(r_v[m]);
    h  = longint'(h_v[m] & 32'hFFFF);
    d  = longint'(d_v[m]);
    sd = longint'(sd_v[m]);
    lw = longint'(l);
    tw = longint'(tlam);
    return (r * 1024 + h) * lw + d * 256 + sd * tw;
  endfunction

  // Winner among enabled modes with index above limit; ascending scan with
  // strict < keeps the lowest index on ties.
  task automatic model(input int limit, output bit have, output int bm,
                       output longint bs, output longint fs);
    longint s;
    have = 0; bm = 0; bs = 0; fs = 0;
    for (int m = 0; m < NM; m++) begin
      if (mask_v[m] && m > limit) begin
        s = cost(m, lam);
        if (!have || s < bs) begin
          have = 1; bm = m; bs = s; fs = cost(m, lamf);
        end
      end
    end
  endtask

  function automatic int max_ofs(input int m);
    int x;
    x = ofs_s[m];
    if (ofs_d[m] > x) x = ofs_d[m];
    if (ofs_r[m] > x) x = ofs_r[m];
    return x;
  endfunction

  task automatic clear_valids();
    bus.sse_valid = 0; bus.disto_valid = 0; bus.rate_valid = 0;
  endtask

  task automatic check_results(input int id, input int limit, input bit full);
    bit have; int bm; longint bs, fs;
    logic [31:0] tag;
    logic [31:0] hi;
    model(limit, have, bm, bs, fs);
    tag = have ? 32'(id * 16 + bm + 1) : 32'd0;
    hi  = have ? ~tag : 32'd0;
    check_val("best_mode", 64'(bus.best_mode), 64'(bm));
    check_val("best_score", bus.best_score, bs);
    check_val("best_D", 64'(bus.best_D), have ? 64'(d_v[bm]) : 64'd0);
    check_val("best_SD", 64'(bus.best_SD), have ? 64'(sd_v[bm]) : 64'd0);
    check_val("best_R", 64'(bus.best_R), have ? 64'(r_v[bm]) : 64'd0);
    check_val("payload_lo", 64'(bus.best_payload[31:0]), 64'(tag));
    check_val("payload_hi", 64'(bus.best_payload[PW-1 -: 32]), 64'(hi));
    if (full) begin
      check_val("final_score", bus.final_score, fs);
      check_val("none_valid", 64'(bus.none_valid), 64'(!have));
    end
  endtask

  task automatic run_txn(input int id, input int abort_m, input int reset_m);
    int cycle, es_cyc, cur, done_cnt, exp_lat, lastv, off;
    bit active, aborted, was_reset, finished;
    bit es, dn, bsy;
    logic [MW-1:0] em;
    int got_modes[$];
    int exp_modes[$];

    for (int m = 0; m < NM; m++) begin
      case (hs)
        1: begin ofs_r[m] = 0; ofs_d[m] = 1; ofs_s[m] = 2; end
        2: begin ofs_r[m] = 0; ofs_d[m] = 0; ofs_s[m] = 0; end
        3: begin ofs_r[m] = 1; ofs_d[m] = 2; ofs_s[m] = 2; end
        default: begin
          ofs_r[m] = $urandom_range(3);
          ofs_d[m] = $urandom_range(3);
          ofs_s[m] = $urandom_range(3);
        end
      endcase
    end
    exp_lat = 1;
    for (int m = NM - 1; m >= 0; m--) begin
      if (mask_v[m]) begin
        exp_modes.push_back(m);
        exp_lat += 3 + max_ofs(m) + 1;
      end else begin
        exp_lat += 1;
      end
    end

    @(negedge clk);
    bus.mode_mask = mask_v;
    for (int m = 0; m < NM; m++) bus.fixed_cost[16*m +: 16] = h_v[m][15:0];
    bus.lambda_sel = lam; bus.tlambda = tlam; bus.lambda_final = lamf;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    cycle = 1; cur = 0; es_cyc = 0; lastv = 0; done_cnt = 0;
    active = 0; aborted = 0; was_reset = 0; finished = 0;
    check_val("busy_after_start", 64'(bus.busy), 64'd1);

    while (cycle <= 600 && !finished && !aborted && !was_reset) begin
      es = bus.eval_start; em = bus.eval_mode; dn = bus.done; bsy = bus.busy;
      clear_valids();
      if (es) begin
        got_modes.push_back(int'(em));
        cur = int'(em); es_cyc = cycle; active = 1; lastv = 0;
        bus.payload = '0;
        bus.payload[31:0] = 32'(id * 16 + cur + 1);
        bus.payload[PW-1 -: 32] = ~32'(id * 16 + cur + 1);
        if (cur == abort_m) begin
          bus.abort = 1; aborted = 1; active = 0;
        end
      end
      if (active) begin
        off = cycle - es_cyc;
        if (hs == 3 && off == 0) begin bus.sse_valid = 1; bus.sse = $urandom; end
        if (off == ofs_r[cur]) begin bus.rate_valid = 1;  bus.rate = r_v[cur]; end
        if (off == ofs_d[cur]) begin bus.disto_valid = 1; bus.disto = sd_v[cur]; end
        if (off == ofs_s[cur]) begin bus.sse_valid = 1;   bus.sse = d_v[cur]; end
        if (off == max_ofs(cur)) begin active = 0; lastv = cycle; end
      end else if (!aborted && $urandom_range(3) == 0) begin
        bus.sse_valid = 1;   bus.sse = $urandom;
        bus.rate_valid = 1;  bus.rate = $urandom;
        bus.disto_valid = 1; bus.disto = $urandom;
      end
      if (reset_m >= 0 && cur == reset_m && lastv > 0 && cycle == lastv + 2) begin
        rst_n = 0;
        #1;
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_done", 64'(bus.done), 64'd0);
        check_val("rst_eval_start", 64'(bus.eval_start), 64'd0);
        check_val("rst_eval_mode", 64'(bus.eval_mode), 64'd0);
        check_val("rst_best_mode", 64'(bus.best_mode), 64'd0);
        check_val("rst_best_score", bus.best_score, 64'd0);
        check_val("rst_final_score", bus.final_score, 64'd0);
        check_val("rst_best_D", 64'(bus.best_D), 64'd0);
        check_val("rst_payload", 64'(bus.best_payload[31:0]), 64'd0);
        was_reset = 1;
      end
      if (dn) begin
        done_cnt++;
        check_val("busy_at_done", 64'(bsy), 64'd1);
        finished = 1;
      end
      if (!finished && !aborted && !was_reset) begin
        @(negedge clk);
        cycle++;
      end
    end
    clear_valids();

    if (was_reset) begin
      @(negedge clk);
      rst_n = 1;
      $display("txn %0d mask=%b reset in COMP of mode %0d", id, mask_v, reset_m);
      return;
    end
    if (aborted) begin
      @(negedge clk);
      bus.abort = 0;
      check_val("abort_idle", 64'(bus.busy), 64'd0);
      for (int i = 0; i < 6; i++) begin
        if (bus.done) done_cnt++;
        @(negedge clk);
      end
      check_val("abort_no_done", 64'(done_cnt), 64'd0);
      check_results(id, abort_m, 0);
      $display("txn %0d mask=%b aborted at mode %0d best_mode=%0d", id, mask_v, abort_m, bus.best_mode);
      return;
    end
    if (!finished) check_val("done_timeout", 64'd0, 64'd1);
    if (mask_v != 0) check_val("latency", 64'(cycle), 64'(exp_lat));
    check_val("eval_count", 64'(got_modes.size()), 64'(exp_modes.size()));
    for (int i = 0; i < exp_modes.size() && i < got_modes.size(); i++)
      check_val("eval_mode", 64'(got_modes[i]), 64'(exp_modes[i]));
    check_results(id, -1, 1);
    @(negedge clk);
    check_val("done_once", 64'(bus.done), 64'd0);
    check_val("idle_after_done", 64'(bus.busy), 64'd0);
    $display("txn %0d mask=%b hs=%0d best_mode=%0d best_score=%0d final=%0d lat=%0d",
             id, mask_v, hs, bus.best_mode, $signed(bus.best_score), $signed(bus.final_score), cycle);
  endtask

  task automatic basic_setup();
    mask_v = 4'hF; lam = 1; tlam = 0; lamf = 2; hs = 0;
    h_v[3] = 919; h_v[2] = 872; h_v[1] = 919; h_v[0] = 663;
    d_v[3] = 10;  d_v[2] = 5;   d_v[1] = 7;   d_v[0] = 6;
    for (int m = 0; m < NM; m++) begin r_v[m] = 0; sd_v[m] = 0; end
  endtask

  task automatic random_setup();
    mask_v = 4'($urandom);
    lam = $urandom; tlam = $urandom; lamf = $urandom;
    for (int m = 0; m < NM; m++) begin
      h_v[m] = $urandom_range(16'hFFFF);
      d_v[m] = $urandom; sd_v[m] = $urandom; r_v[m] = $urandom;
    end
  endtask

  initial begin
    bus.start = 0; bus.abort = 0; bus.mode_mask = '0; bus.fixed_cost = '0;
    bus.lambda_sel = 0; bus.tlambda = 0; bus.lambda_final = 0;
    bus.sse = 0; bus.disto = 0; bus.rate = 0; bus.payload = '0;
    clear_valids();
    repeat (3) @(negedge clk);
    check_val("reset_busy", 64'(bus.busy), 64'd0);
    check_val("reset_done", 64'(bus.done), 64'd0);
    check_val("reset_eval_start", 64'(bus.eval_start), 64'd0);
    check_val("reset_best_score", bus.best_score, 64'd0);
    check_val("reset_none_valid", 64'(bus.none_valid), 64'd0);
    rst_n = 1;
    @(negedge clk);
    check_val("post_reset_busy", 64'(bus.busy), 64'd0);

    basic_setup();
    run_txn(1, -1, -1);

    basic_setup();
    h_v[3] = 100; h_v[2] = 208; h_v[1] = 100; h_v[0] = 208;
    d_v[3] = 10;  d_v[2] = 7;   d_v[1] = 10;  d_v[0] = 7;
    run_txn(2, -1, -1);

    basic_setup(); lam = -1;
    run_txn(3, -1, -1);

    basic_setup(); mask_v = 4'b0100;
    run_txn(4, -1, -1);

    basic_setup(); mask_v = 4'b0000;
    run_txn(5, -1, -1);

    random_setup(); mask_v = 4'hF;
    for (int k = 1; k <= 3; k++) begin
      hs = k;
      run_txn(5 + k, -1, -1);
    end

    basic_setup();
    run_txn(9, 2, -1);
    basic_setup();
    run_txn(10, -1, -1);

    basic_setup();
    run_txn(11, -1, 2);
    basic_setup(); hs = 2;
    run_txn(12, -1, -1);

    for (int t = 0; t < 30; t++) begin
      random_setup();
      hs = $urandom_range(3);
      run_txn(20 + t, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
